zaxxon_wave_player: RTL and testbench

ZAXXON_WAVE_PLAYER -- requirements
Module: zaxxon_wave_player

---
 rtl/zaxxon_wave_pkg.sv | 39 +++
 rtl/zaxxon_wave_channel.sv | 64 ++++++
 rtl/zaxxon_wave_player.sv | 142 ++++++++++++++
 tb/tb_zaxxon_wave_player.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/zaxxon_wave_pkg.sv
// Shared constants, address tables and FSM encoding
// for the four-channel Zaxxon sample player.
package zaxxon_wave_pkg;

  localparam int NUM_CH     = 4;
  localparam int SAMPLE_DIV = 4354;
  localparam int READ_LAT   = 8;

  // Index 0 is the least significant element.
  localparam logic [NUM_CH-1:0][19:0] START_ADDR = {
    20'h00400, 20'h00300, 20'h00200, 20'h00100
  };
  localparam logic [NUM_CH-1:0][19:0] END_ADDR = {
    20'h00407, 20'h00305, 20'h00203, 20'h00103
  };

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_ISSUE,
    S_WAIT,
    S_ACCUM,
    S_NEXT,
    S_OUTPUT
  } state_e;

  function automatic logic [19:0] start_of(
    input logic [1:0] ch
  );
    return START_ADDR[ch];
  endfunction

  function automatic logic [19:0] end_of(
    input logic [1:0] ch
  );
    return END_ADDR[ch];
  endfunction

endpackage

// File: rtl/zaxxon_wave_channel.sv
// One playback channel: trigger edge detect, pending flag,
// active flag and byte pointer. Ports: apply/advance strobes
// from the sequencer; active/ptr back to it.
module zaxxon_wave_channel
  import zaxxon_wave_pkg::*;
#(
  parameter int unsigned CH = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        trigger,
  input  logic        loop_en,
  input  logic        apply,
  input  logic        advance,
  output logic        active,
  output logic [19:0] ptr
);

  localparam logic [19:0] START = start_of(2'(CH));
  localparam logic [19:0] STOP  = end_of(2'(CH));

  logic        trig_q;
  logic        pend_q, pend_d;
  logic        act_q, act_d;
  logic [19:0] ptr_q, ptr_d;

  always_comb begin
    pend_d = pend_q;
    act_d  = act_q;
    ptr_d  = ptr_q;
    if (apply) pend_d = 1'b0;
    // A new edge outranks the clear so it is never lost.
    if (trigger && !trig_q) pend_d = 1'b1;
    if (apply && pend_q) begin
      ptr_d = START;
      act_d = 1'b1;
    end else if (advance) begin
      if (ptr_q == STOP) begin
        if (loop_en) ptr_d = START;
        else         act_d = 1'b0;
      end else begin
        ptr_d = ptr_q + 20'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trig_q <= 1'b0;
      pend_q <= 1'b0;
      act_q  <= 1'b0;
      ptr_q  <= '0;
    end else begin
      trig_q <= trigger;
      pend_q <= pend_d;
      act_q  <= act_d;
      ptr_q  <= ptr_d;
    end
  end

  assign active = act_q;
  assign ptr    = ptr_q;

endmodule

// File: rtl/zaxxon_wave_player.sv
// Four-channel 8-bit sample player: sample-rate divider,
// SDRAM fetch sequencer and mixer. Ports: trigger/loop_en per
// channel, wave_addr/wave_rd/wave_data to SDRAM,
// audio_out mixed sample, busy per-channel active flags.
module zaxxon_wave_player
  import zaxxon_wave_pkg::*;
#(
  parameter int unsigned DIV = SAMPLE_DIV
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  trigger,
  input  logic [3:0]  loop_en,
  output logic [19:0] wave_addr,
  output logic        wave_rd,
  input  logic [15:0] wave_data,
  output logic [15:0] audio_out,
  output logic [3:0]  busy
);

  logic [15:0] div_q, div_d;
  logic        tick;
  state_e      state_q, state_d;
  logic [1:0]  ch_q, ch_d;
  logic [3:0]  lat_q, lat_d;
  logic [15:0] data_q, data_d;
  logic [9:0]  acc_q, acc_d;
  logic [15:0] audio_q, audio_d;

  logic [NUM_CH-1:0] active;
  logic [NUM_CH-1:0] adv;
  logic              apply;
  logic [19:0]       ptr [NUM_CH];
  logic [19:0]       ptr_sel;
  logic [7:0]        smp;

  assign tick    = (div_q == 16'(DIV - 1));
  assign apply   = (state_q == S_APPLY);
  assign ptr_sel = ptr[ch_q];
  // byte - 128 in two's complement is byte ^ 0x80.
  assign smp = (ptr_sel[0] ? data_q[15:8] : data_q[7:0])
             ^ 8'h80;

  always_comb begin
    adv = '0;
    if (state_q == S_ACCUM) adv = 4'(1) << ch_q;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    zaxxon_wave_channel #(
      .CH(i)
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .trigger(trigger[i]),
      .loop_en(loop_en[i]),
      .apply  (apply),
      .advance(adv[i]),
      .active (active[i]),
      .ptr    (ptr[i])
    );
  end

  always_comb begin
    div_d   = tick ? '0 : div_q + 16'd1;
    state_d = state_q;
    ch_d    = ch_q;
    lat_d   = lat_q;
    data_d  = data_q;
    acc_d   = acc_q;
    audio_d = audio_q;
    unique case (state_q)
      S_IDLE: if (tick) state_d = S_APPLY;
      S_APPLY: begin
        acc_d   = '0;
        ch_d    = '0;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (!active[ch_q]) begin
          state_d = S_NEXT;
        end else begin
          lat_d   = 4'(READ_LAT);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (lat_q == '0) begin
          data_d  = wave_data;
          state_d = S_ACCUM;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      S_ACCUM: begin
        acc_d   = acc_q + {{2{smp[7]}}, smp};
        state_d = S_NEXT;
      end
      S_NEXT: begin
        if (ch_q == 2'(NUM_CH - 1)) begin
          state_d = S_OUTPUT;
        end else begin
          ch_d    = ch_q + 2'd1;
          state_d = S_ISSUE;
        end
      end
      S_OUTPUT: begin
        audio_d = {acc_q, 6'b0};
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q   <= '0;
      state_q <= S_IDLE;
      ch_q    <= '0;
      lat_q   <= '0;
      data_q  <= '0;
      acc_q   <= '0;
      audio_q <= '0;
    end else begin
      div_q   <= div_d;
      state_q <= state_d;
      ch_q    <= ch_d;
      lat_q   <= lat_d;
      data_q  <= data_d;
      acc_q   <= acc_d;
      audio_q <= audio_d;
    end
  end

  // Strobe and address are decoded straight from flops so the
  // pulse lives exactly in the ISSUE cycle of an active channel.
  assign wave_rd   = (state_q == S_ISSUE) && active[ch_q];
  assign wave_addr = {ptr_sel[19:1], 1'b0};
  assign audio_out = audio_q;
  assign busy      = active;

endmodule

// File: tb/tb_zaxxon_wave_player.sv
// Self-checking bench for zaxxon_wave_player with an SDRAM
// model and a per-tick behavioural mixer reference.
module tb_zaxxon_wave_player;

  localparam int DIV = 100;
  localparam int CHK = 60;
  localparam int LAT = 8;
  localparam logic [19:0] T_START [4] = '{
    20'h00100, 20'h00200, 20'h00300, 20'h00400};
  localparam logic [19:0] T_END [4] = '{
    20'h00103, 20'h00203, 20'h00305, 20'h00407};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  trigger = '0;
  logic [3:0]  loop_en = '0;
  logic [19:0] wave_addr;
  logic        wave_rd;
  logic [15:0] wave_data;
  logic [15:0] audio_out;
  logic [3:0]  busy;

  always #5 clk = ~clk;

  zaxxon_wave_player #(
    .DIV(DIV)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .trigger  (trigger),
    .loop_en  (loop_en),
    .wave_addr(wave_addr),
    .wave_rd  (wave_rd),
    .wave_data(wave_data),
    .audio_out(audio_out),
    .busy     (busy)
  );

  logic [7:0] mem [2048];
  int n_cmp = 0;
  int n_bad = 0;
  int edges = 0;

  logic [19:0] m_ptr [4];
  logic [3:0]  m_act;
  logic [3:0]  m_pend;
  logic [15:0] e_audio;
  logic [19:0] e_addr [$];

  logic [19:0] rd_addr [$];
  int          rd_time [$];
  int          ncyc = 0;
  int          dly = 0;
  logic [19:0] pend_addr = '0;

  // SDRAM model: garbage on the bus until the word is due.
  always @(negedge clk) begin
    ncyc <= ncyc + 1;
    if (wave_rd) begin
      rd_addr.push_back(wave_addr);
      rd_time.push_back(ncyc);
      pend_addr <= wave_addr;
      dly       <= LAT + 1;
      wave_data <= 16'($urandom);
    end else if (dly == 1) begin
      dly       <= 0;
      wave_data <= {mem[{pend_addr[10:1], 1'b1}],
                    mem[{pend_addr[10:1], 1'b0}]};
    end else if (dly > 1) begin
      dly <= dly - 1;
    end
  end

  task automatic step();
    @(posedge clk);
    edges++;
    #1;
  endtask

  task automatic to_phase(input int ph);
    int n = 0;
    do begin
      step();
      n++;
    end while ((edges % DIV) != ph && n < 4 * DIV);
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_act  = '0;
    m_pend = '0;
    for (int c = 0; c < 4; c++) m_ptr[c] = '0;
    e_audio = '0;
    e_addr.delete();
  endtask

  // One sample period: restarts, then each live channel adds
  // (byte - 128) and moves its pointer.
  task automatic model_tick();
    int acc;
    logic [7:0] b;
    acc = 0;
    e_addr.delete();
    for (int c = 0; c < 4; c++)
      if (m_pend[c]) begin
        m_ptr[c]  = T_START[c];
        m_act[c]  = 1'b1;
        m_pend[c] = 1'b0;
      end
    for (int c = 0; c < 4; c++)
      if (m_act[c]) begin
        e_addr.push_back({m_ptr[c][19:1], 1'b0});
        b = mem[m_ptr[c][10:0]];
        acc += int'(b) - 128;
        if (m_ptr[c] == T_END[c]) begin
          if (loop_en[c]) m_ptr[c] = T_START[c];
          else            m_act[c] = 1'b0;
        end else begin
          m_ptr[c] = m_ptr[c] + 20'd1;
        end
      end
    e_audio = 16'(acc * 64);
  endtask

  task automatic fire(input logic [3:0] m);
    trigger = trigger | m;
    m_pend  = m_pend | m;
    step();
    trigger = trigger & ~m;
    step();
  endtask

  task automatic do_tick();
    rd_addr.delete();
    rd_time.delete();
    to_phase(0);
    model_tick();
  endtask

  task automatic verify(input string tag);
    to_phase(CHK);
    chk({tag, " audio"}, 32'(audio_out), 32'(e_audio));
    chk({tag, " busy"}, 32'(busy), 32'(m_act));
    chk({tag, " nrd"}, rd_addr.size(), e_addr.size());
    for (int i = 0; i < e_addr.size() && i < rd_addr.size(); i++)
      chk({tag, " addr"}, 32'(rd_addr[i]), 32'(e_addr[i]));
    for (int i = 1; i < rd_time.size(); i++) begin
      n_cmp++;
      assert (rd_time[i] - rd_time[i-1] >= LAT) else begin
        n_bad++;
        $error("FAIL %s gap: got %0d expected >= %0d",
               tag, rd_time[i] - rd_time[i-1], LAT);
      end
    end
  endtask

  task automatic fill_rand();
    for (int a = 'h100; a < 'h500; a++) mem[a] = 8'($urandom);
  endtask

  initial begin
    for (int a = 0; a < 2048; a++) mem[a] = 8'h80;
    model_reset();
    step();
    step();
    chk("rst audio", 32'(audio_out), 32'h0);
    chk("rst busy", 32'(busy), 32'h0);
    chk("rst rd", 32'(wave_rd), 32'h0);
    chk("rst addr", 32'(wave_addr), 32'h0);
    reset = 1'b0;
    edges = 0;

    for (int t = 0; t < 3; t++) begin
      do_tick();
      verify("idle");
    end

    mem['h100] = 8'h80;
    mem['h101] = 8'hFF;
    mem['h102] = 8'h40;
    mem['h103] = 8'h00;
    loop_en = 4'b0000;
    fire(4'b0001);
    for (int t = 0; t < 5; t++) begin
      do_tick();
      verify("single");
    end

    loop_en = 4'b0001;
    fire(4'b0001);
    for (int t = 0; t < 6; t++) begin
      do_tick();
      verify("loop");
    end
    loop_en = 4'b0000;

    for (int a = 'h100; a < 'h500; a++) mem[a] = 8'hFF;
    fire(4'b1111);
    do_tick();
    verify("mix");
    chk("mix const", 32'(audio_out), 32'h7F00);

    fill_rand();
    fire(4'b0010);
    do_tick();
    to_phase(5);
    fire(4'b0010);
    fire(4'b0010);
    verify("retrig mid");
    for (int t = 0; t < 3; t++) begin
      do_tick();
      verify("retrig run");
    end
    do_tick();
    to_phase(5);
    fire(4'b0010);
    verify("retrig end");
    do_tick();
    verify("retrig restart");

    fire(4'b0001);
    do_tick();
    to_phase(5);
    reset = 1'b1;
    #1;
    chk("wait rst audio", 32'(audio_out), 32'h0);
    chk("wait rst busy", 32'(busy), 32'h0);
    chk("wait rst rd", 32'(wave_rd), 32'h0);
    chk("wait rst addr", 32'(wave_addr), 32'h0);
    step();
    step();
    reset = 1'b0;
    edges = 0;
    model_reset();
    rd_addr.delete();
    rd_time.delete();
    to_phase(DIV - 2);
    chk("post rst nrd", rd_addr.size(), 0);
    do_tick();
    verify("post rst");

    for (int t = 0; t < 14; t++) begin
      fill_rand();
      loop_en = 4'($urandom);
      fire(4'($urandom));
      do_tick();
      if ($urandom_range(0, 1) == 1) begin
        to_phase(5);
        fire(4'($urandom));
      end
      verify("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
